// File: rtl/move_input_conditioner.sv
// Turns four raw push-buttons into one handshaked move stream: synchronise,
// debounce, arbitrate (up > down > left > right), then issue with auto-repeat.
module move_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 15,
  parameter int REPEAT_RATE     = 4,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic       CLOCK_25,
  input  logic       reset_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       frame_tick,
  input  logic       enable,
  input  logic       move_ready,
  output logic       move_valid,
  output logic [1:0] move_dir,
  output logic [3:0] btn_stable,
  output logic       held
);

  // state  | meaning
  // IDLE   | no direction held; issues as soon as a debounced button is seen
  // DELAY  | direction issued, counting frames to the first auto-repeat
  // REPEAT | auto-repeating the held direction every REPEAT_RATE frames
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DELAY  = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  localparam int             DB_W       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0]     DELAY_LOAD = 8'(REPEAT_DELAY - 1);
  localparam logic [7:0]     RATE_LOAD  = 8'(REPEAT_RATE - 1);

  logic [3:0]      btn_raw;
  logic [3:0]      btn_pressed;
  logic [3:0]      sync_1;
  logic [3:0]      sync_2;
  logic [DB_W-1:0] db_cnt [4];

  logic       any;
  logic [1:0] sel;
  logic [1:0] state, state_nxt;
  logic [1:0] cur, cur_nxt;
  logic [7:0] fcnt, fcnt_nxt;
  logic       issue;

  assign btn_raw     = {btn_right, btn_left, btn_down, btn_up};
  assign btn_pressed = BTN_ACTIVE_LOW ? ~btn_raw : btn_raw;

  always_ff @(posedge CLOCK_25 or negedge reset_n) begin
    if (!reset_n) begin
      sync_1 <= '0;
      sync_2 <= '0;
    end else begin
      sync_1 <= btn_pressed;
      sync_2 <= sync_1;
    end
  end

  always_ff @(posedge CLOCK_25 or negedge reset_n) begin
    if (!reset_n) begin
      btn_stable <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync_2[i] == btn_stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          btn_stable[i] <= ~btn_stable[i];
          db_cnt[i]     <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    any = |btn_stable;
    sel = 2'd3;
    if (btn_stable[0])      sel = 2'd0;
    else if (btn_stable[1]) sel = 2'd1;
    else if (btn_stable[2]) sel = 2'd2;
  end

  // fcnt is a down-counter; an issue fires on the tick that finds it at zero
  always_comb begin
    state_nxt = state;
    cur_nxt   = cur;
    fcnt_nxt  = fcnt;
    issue     = 1'b0;
    if (!enable) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any) begin
            issue     = 1'b1;
            cur_nxt   = sel;
            fcnt_nxt  = DELAY_LOAD;
            state_nxt = ST_DELAY;
          end
        end
        ST_DELAY, ST_REPEAT: begin
          if (!any || (sel != cur)) begin
            state_nxt = ST_IDLE;
          end else if (frame_tick) begin
            if (fcnt == 8'd0) begin
              issue     = 1'b1;
              fcnt_nxt  = RATE_LOAD;
              state_nxt = ST_REPEAT;
            end else begin
              fcnt_nxt = fcnt - 8'd1;
            end
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_25 or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      cur   <= 2'd0;
      fcnt  <= 8'd0;
    end else begin
      state <= state_nxt;
      cur   <= cur_nxt;
      fcnt  <= fcnt_nxt;
    end
  end

  // An issue is only taken when the slot is free or being freed this cycle
  always_ff @(posedge CLOCK_25 or negedge reset_n) begin
    if (!reset_n) begin
      move_valid <= 1'b0;
      move_dir   <= 2'd0;
    end else if (!enable) begin
      move_valid <= 1'b0;
    end else if (issue && (!move_valid || move_ready)) begin
      move_valid <= 1'b1;
      move_dir   <= cur_nxt;
    end else if (move_valid && move_ready) begin
      move_valid <= 1'b0;
    end
  end

  assign held = (state != ST_IDLE);

endmodule

// File: tb/tb_move_input_conditioner.sv
// Bench for move_input_conditioner: directed scenarios with literal expectations,
// then random buttons/ticks/ready/enable checked every cycle against a frame-count model.
module tb_move_input_conditioner;

  localparam int DB = 8;
  localparam int RD = 3;
  localparam int RR = 2;

  logic       CLOCK_25;
  logic       reset_n;
  logic       btn_up, btn_down, btn_left, btn_right;
  logic       frame_tick;
  logic       enable;
  logic       move_ready;
  logic       move_valid;
  logic [1:0] move_dir;
  logic [3:0] btn_stable;
  logic       held;

  int n_assert = 0;
  int n_fail   = 0;
  int acc_cnt  = 0;
  int acc_base = 0;
  bit cmp_en   = 1'b0;

  move_input_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY(RD),
    .REPEAT_RATE(RR),
    .BTN_ACTIVE_LOW(1'b1)
  ) dut (
    .CLOCK_25(CLOCK_25),
    .reset_n(reset_n),
    .btn_up(btn_up),
    .btn_down(btn_down),
    .btn_left(btn_left),
    .btn_right(btn_right),
    .frame_tick(frame_tick),
    .enable(enable),
    .move_ready(move_ready),
    .move_valid(move_valid),
    .move_dir(move_dir),
    .btn_stable(btn_stable),
    .held(held)
  );

  initial CLOCK_25 = 1'b0;
  always #5 CLOCK_25 = ~CLOCK_25;

  // Reference model: pins seen two cycles late, flipped after DB consecutive
  // disagreeing cycles; repeats decided by how many ticks the hold has counted.
  logic [3:0] m_s1, m_s2, m_stable;
  int         m_run [4];
  logic       m_held;
  logic [1:0] m_cur;
  int         m_n;
  logic       m_valid;
  logic [1:0] m_dir;

  logic [3:0] nx_s1, nx_s2, nx_stable;
  int         nx_run [4];
  logic       nx_held;
  logic [1:0] nx_cur;
  int         nx_n;
  logic       nx_valid;
  logic [1:0] nx_dir;
  logic       m_any;
  logic [1:0] m_sel;
  logic       m_found;
  logic       m_issue;
  logic [1:0] m_idir;

  always_comb begin
    nx_s1     = ~{btn_right, btn_left, btn_down, btn_up};
    nx_s2     = m_s1;
    nx_stable = m_stable;
    nx_run    = m_run;
    for (int i = 0; i < 4; i++) begin
      if (m_s2[i] != m_stable[i]) begin
        if (m_run[i] + 1 >= DB) begin
          nx_stable[i] = ~m_stable[i];
          nx_run[i]    = 0;
        end else begin
          nx_run[i] = m_run[i] + 1;
        end
      end else begin
        nx_run[i] = 0;
      end
    end

    m_any   = |m_stable;
    m_sel   = 2'd0;
    m_found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (m_stable[i] && !m_found) begin
        m_sel   = 2'(i);
        m_found = 1'b1;
      end
    end

    m_issue = 1'b0;
    m_idir  = m_cur;
    nx_held = m_held;
    nx_cur  = m_cur;
    nx_n    = m_n;
    if (!enable) begin
      nx_held = 1'b0;
    end else if (!m_held) begin
      if (m_any) begin
        m_issue = 1'b1;
        m_idir  = m_sel;
        nx_held = 1'b1;
        nx_cur  = m_sel;
        nx_n    = 0;
      end
    end else if (!m_any || m_sel != m_cur) begin
      nx_held = 1'b0;
    end else if (frame_tick) begin
      nx_n = m_n + 1;
      if (nx_n == RD || (nx_n > RD && ((nx_n - RD) % RR) == 0)) m_issue = 1'b1;
    end

    nx_valid = m_valid && !move_ready;
    nx_dir   = m_dir;
    if (m_issue && (!m_valid || move_ready)) begin
      nx_valid = 1'b1;
      nx_dir   = m_idir;
    end
    if (!enable) nx_valid = 1'b0;
  end

  always @(posedge CLOCK_25 or negedge reset_n) begin
    if (!reset_n) begin
      m_s1     <= '0;
      m_s2     <= '0;
      m_stable <= '0;
      for (int i = 0; i < 4; i++) m_run[i] <= 0;
      m_held   <= 1'b0;
      m_cur    <= 2'd0;
      m_n      <= 0;
      m_valid  <= 1'b0;
      m_dir    <= 2'd0;
    end else begin
      m_s1     <= nx_s1;
      m_s2     <= nx_s2;
      m_stable <= nx_stable;
      m_run    <= nx_run;
      m_held   <= nx_held;
      m_cur    <= nx_cur;
      m_n      <= nx_n;
      m_valid  <= nx_valid;
      m_dir    <= nx_dir;
    end
  end

  always @(negedge CLOCK_25) begin
    if (move_valid && move_ready) acc_cnt++;
    if (cmp_en) begin
      n_assert++;
      if (btn_stable !== m_stable) begin
        n_fail++;
        $display("FAIL model_stable t=%0t: got %b expected %b", $time, btn_stable, m_stable);
      end
      n_assert++;
      if (move_valid !== m_valid) begin
        n_fail++;
        $display("FAIL model_valid t=%0t: got %b expected %b", $time, move_valid, m_valid);
      end
      n_assert++;
      if (held !== m_held) begin
        n_fail++;
        $display("FAIL model_held t=%0t: got %b expected %b", $time, held, m_held);
      end
      if (m_valid) begin
        n_assert++;
        if (move_dir !== m_dir) begin
          n_fail++;
          $display("FAIL model_dir t=%0t: got %0d expected %0d", $time, move_dir, m_dir);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLOCK_25);
    #2;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
  endtask

  initial begin
    reset_n    = 1'b0;
    btn_up     = 1'b1;
    btn_down   = 1'b1;
    btn_left   = 1'b1;
    btn_right  = 1'b1;
    frame_tick = 1'b0;
    enable     = 1'b1;
    move_ready = 1'b1;
    step(3);
    check("rst_stable", 32'(btn_stable), 0);
    check("rst_valid", 32'(move_valid), 0);
    check("rst_held", 32'(held), 0);
    check("rst_dir", 32'(move_dir), 0);
    reset_n = 1'b1;
    cmp_en  = 1'b1;
    step(2);

    // glitch shorter than the debounce window
    btn_up = 1'b0;
    step(5);
    btn_up = 1'b1;
    step(12);
    check("glitch_stable", 32'(btn_stable), 0);
    check("glitch_valid", 32'(move_valid), 0);

    // first press latency
    btn_right = 1'b0;
    step(9);
    check("press_stable_early", 32'(btn_stable[3]), 0);
    step(1);
    check("press_stable", 32'(btn_stable[3]), 1);
    check("press_valid_early", 32'(move_valid), 0);
    step(1);
    check("press_valid", 32'(move_valid), 1);
    check("press_dir", 32'(move_dir), 3);
    check("press_held", 32'(held), 1);
    step(1);
    check("press_pulse_end", 32'(move_valid), 0);

    // auto-repeat cadence: press, tick 3, then 5, 7, 9
    btn_right = 1'b1;
    step(12);
    acc_base = acc_cnt;
    btn_left = 1'b0;
    step(12);
    for (int t = 1; t <= 9; t++) begin
      tick();
      check("repeat_valid_after_tick", 32'(move_valid),
            32'((t == 3 || t == 5 || t == 7 || t == 9) ? 1 : 0));
      step(2);
    end
    check("repeat_count", 32'(acc_cnt - acc_base), 5);
    check("repeat_held", 32'(held), 1);

    // backpressure: no backlog behind a stalled request
    btn_left = 1'b1;
    step(12);
    move_ready = 1'b0;
    btn_down = 1'b0;
    step(11);
    check("stall_valid", 32'(move_valid), 1);
    check("stall_dir", 32'(move_dir), 1);
    for (int t = 1; t <= 13; t++) begin
      tick();
      check("stall_hold_valid", 32'(move_valid), 1);
      check("stall_hold_dir", 32'(move_dir), 1);
      step(1);
    end
    acc_base   = acc_cnt;
    move_ready = 1'b1;
    step(1);
    move_ready = 1'b0;
    check("stall_drain", 32'(move_valid), 0);
    step(3);
    check("stall_one_accept", 32'(acc_cnt - acc_base), 1);
    check("stall_no_backlog", 32'(move_valid), 0);
    tick();
    check("stall_tick14", 32'(move_valid), 0);
    step(1);
    tick();
    check("stall_tick15", 32'(move_valid), 1);
    check("stall_tick15_dir", 32'(move_dir), 1);

    // direction change passes through IDLE and restarts the delay
    btn_down   = 1'b1;
    move_ready = 1'b1;
    step(12);
    btn_left = 1'b0;
    step(11);
    check("chg_left_valid", 32'(move_valid), 1);
    check("chg_left_dir", 32'(move_dir), 2);
    step(4);
    btn_up = 1'b0;
    step(10);
    check("chg_stable", 32'(btn_stable), 32'h5);
    check("chg_held_before", 32'(held), 1);
    step(1);
    check("chg_idle", 32'(held), 0);
    check("chg_valid_early", 32'(move_valid), 0);
    step(1);
    check("chg_valid", 32'(move_valid), 1);
    check("chg_dir", 32'(move_dir), 0);
    step(1);
    tick();
    check("chg_delay1", 32'(move_valid), 0);
    tick();
    check("chg_delay2", 32'(move_valid), 0);
    move_ready = 1'b0;
    tick();
    check("chg_delay3", 32'(move_valid), 1);
    check("chg_delay3_dir", 32'(move_dir), 0);
    step(1);
    check("chg_repeat_held", 32'(held), 1);

    // async reset mid-REPEAT, then enable gating
    #1;
    reset_n = 1'b0;
    #1;
    check("async_valid", 32'(move_valid), 0);
    check("async_held", 32'(held), 0);
    check("async_stable", 32'(btn_stable), 0);
    check("async_dir", 32'(move_dir), 0);
    enable  = 1'b0;
    reset_n = 1'b1;
    step(15);
    check("dis_stable", 32'(btn_stable), 32'h5);
    check("dis_valid", 32'(move_valid), 0);
    check("dis_held", 32'(held), 0);
    enable = 1'b1;
    step(1);
    check("en_valid", 32'(move_valid), 1);
    check("en_dir", 32'(move_dir), 0);
    check("en_held", 32'(held), 1);
    enable = 1'b0;
    step(1);
    check("dis_clear", 32'(move_valid), 0);
    enable = 1'b1;

    // random traffic against the model
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 39) == 0) btn_up    = ~btn_up;
      if ($urandom_range(0, 39) == 0) btn_down  = ~btn_down;
      if ($urandom_range(0, 39) == 0) btn_left  = ~btn_left;
      if ($urandom_range(0, 39) == 0) btn_right = ~btn_right;
      frame_tick = ($urandom_range(0, 5) == 0);
      move_ready = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 99) == 0) enable = ~enable;
      step(1);
    end
    frame_tick = 1'b0;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/move_input_conditioner.md
Name: move_input_conditioner

Overview:
- Sits directly upstream of the player stage and replaces its raw btn_up/btn_down/btn_left/btn_right inputs with one clean move command stream.
- Synchronises and debounces the four push-buttons, then arbitrates them to a single direction.
- Issues a move request on the initial press, then auto-repeats at frame rate while the button is held.
- Requests are offered through a valid/ready handshake, so the player accepts a step only when it can apply it.

Parameters:
DEBOUNCE_CYCLES, 250000, consecutive CLOCK_25 cycles a synced input must differ from its stable value before the stable value flips (10 ms)
REPEAT_DELAY, 15, frame_tick count from the first issue to the first auto-repeat
REPEAT_RATE, 4, frame_tick count between subsequent auto-repeats
BTN_ACTIVE_LOW, 1, 1 means raw button pins read 0 when pressed

Ports:
CLOCK_25  in  1  pixel clock, sole clock domain
reset_n  in  1  asynchronous active-low reset
btn_up / btn_down / btn_left / btn_right  in  1 each  raw asynchronous button pins
frame_tick  in  1  one-cycle pulse per frame (v_counter wrap), synchronous to CLOCK_25
enable  in  1  0 freezes move generation (driven by ~end_game)
move_ready  in  1  player accepts the pending move this cycle
move_valid  out  1  move request pending
move_dir  out  2  0=up, 1=down, 2=left, 3=right; stable while move_valid=1
btn_stable  out  4  debounced pressed state {right,left,down,up}, active-high
held  out  1  FSM is in DELAY or REPEAT

Behaviour:
- Reset (reset_n=0, asynchronous): all sync flops, debounce counters, btn_stable, move_valid, move_dir, held and frame counters clear to 0; FSM goes to IDLE. Release is synchronous to CLOCK_25.
- Input path: polarity correction, then a 2-flop synchroniser per button.
- Debounce (per button): a counter increments while the synced value differs from btn_stable[i] and resets to 0 when they match.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, btn_stable[i] flips on the next edge and the counter clears.
  - Latency from pin change to btn_stable change is 2+DEBOUNCE_CYCLES cycles.
  - Any glitch shorter than DEBOUNCE_CYCLES produces no change.
- Arbitration: sel = highest-priority pressed button, priority up > down > left > right. any = |btn_stable.
- FSM states IDLE, DELAY, REPEAT. fcnt is an 8-bit frame counter.
  - IDLE: if any && enable, issue(sel), latch cur=sel, fcnt=0, go DELAY.
  - DELAY: if !any or sel!=cur, go IDLE. Otherwise each frame_tick increments fcnt; when fcnt reaches REPEAT_DELAY-1 on a tick, issue(cur), fcnt=0, go REPEAT.
  - REPEAT: same exit rule as DELAY; repeats issue(cur) every REPEAT_RATE ticks.
  - Direction change: leaving on sel!=cur passes through IDLE, so the new direction issues 2 cycles after the change.
- issue(d):
  - If move_valid=0, or move_valid=1 && move_ready=1 in the same cycle, the next cycle has move_valid=1, move_dir=d.
  - Otherwise the issue is dropped. There is no queueing; at most one move is ever pending.
- Handshake:
  - move_valid falls the cycle after move_valid && move_ready, unless an issue coincides, in which case it stays 1 with the new dir.
  - move_dir never changes while move_valid=1 && !move_ready.
  - Releasing the button does not withdraw a pending request.
- enable=0:
  - move_valid clears the next cycle, the FSM forces IDLE, and no issue occurs.
  - Debouncers keep running.
  - If enable returns with a button held, IDLE issues immediately.
- A frame_tick arriving in the same cycle the FSM enters DELAY or REPEAT is not counted.
- fcnt saturation is not needed; parameters must be ≥1 and ≤255.

Test Plan:
1. DEBOUNCE_CYCLES=8. Press btn_up (pin low) for 5 cycles, then release -> btn_stable stays 0, move_valid never rises.
2. DEBOUNCE_CYCLES=8, move_ready=1. Hold btn_right -> btn_stable[3]=1 at cycle 10, move_valid pulses one cycle at cycle 11 with dir=3, held=1.
3. REPEAT_DELAY=3, REPEAT_RATE=2, move_ready=1, btn_left held for 9 frame_ticks -> issues at press, after tick 3, then after ticks 5, 7 and 9 (5 total, dir=2).
4. move_ready=0, hold btn_down through 6 repeats -> move_valid stays 1, dir=1; raise move_ready one cycle -> exactly one accept, no backlog, next request only at the next repeat.
5. Hold left, then add up -> a new request with dir=0 two cycles after btn_stable[0] rises, and the repeat timer restarts from REPEAT_DELAY.
6. Assert reset_n=0 mid-REPEAT with move_valid=1 -> all outputs 0 immediately, without a clock edge. With enable=0 and a button held -> move_valid never rises; raising enable issues on the next cycle.
